ysyx22041405_lsu: RTL and testbench
===================================

# ysyx22041405_lsu

Load/store unit directly downstream of the EXU ALU. It takes the ALU `result` as the effective address, plus store data and the funct3 width code, and runs one memory transaction over a valid/ready request/response bus. It aligns and sign/zero-extends load data, and hands the result to WBU through a valid/ready output. One transaction is in flight at a time; non-memory ops pass the ALU result through.

## Interface
- `WIDTH`, 32, datapath and address width (RV32 only).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: EXU presents an op.
- `in_ready` out 1: LSU can accept; equals (state==IDLE).
- `in_addr` in WIDTH: ALU result (effective address, or pass-through value).
- `in_wdata` in WIDTH: store data (rs2).
- `in_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `in_load` in 1: op is a load.
- `in_store` in 1: op is a store; `in_load` and `in_store` are never both 1.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_addr` out WIDTH: word address, {in_addr[31:2],2'b00}.
- `mem_req_wen` out 1: 1 = write.
- `mem_req_wdata` out WIDTH: lane-replicated store data.
- `mem_req_wmask` out 4: byte-lane enables; 0000 for reads.
- `mem_rsp_valid` in 1: response (read data, or write ack).
- `mem_rsp_data` in WIDTH: read word.
- `out_valid` out 1: result ready for WBU.
- `out_ready` in 1: WBU accepts.
- `out_data` out WIDTH: load result, or pass-through address.
- `out_err` out 1: misaligned access or illegal funct3.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE.** Accept on `in_valid && in_ready` and latch all inputs.
  - Non-memory op: `out_data` = `in_addr`, go to DONE.
  - Illegal funct3 (load 011/110/111; store other than 000/001/010) or misalignment (H/HU/SH with addr[0]=1; W with addr[1:0]≠0): `out_err`=1, `out_data`=0, go to DONE. No memory request is issued.
  - Otherwise go to REQ.
- **REQ.** `mem_req_valid`=1, with addr, wen, wdata and wmask held stable until `mem_req_ready`. On handshake go to WAIT.
- **WAIT.** Stay until `mem_rsp_valid`.
  - Load: capture the extracted data.
  - Store: `out_data` = 0.
  - Go to DONE.
- **DONE.** `out_valid`=1, `out_data` and `out_err` stable until `out_ready`. On handshake go to IDLE.
- **Load extract.** Let w = `mem_rsp_data` >> (addr[1:0]*8).
  - B: sign-extend w[7:0]. BU: zero-extend w[7:0].
  - H: sign-extend w[15:0]. HU: zero-extend w[15:0].
  - W: w.
- **Store format.**
  - SB: wdata = {4{d[7:0]}}, wmask = 0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, wmask = 0011 << addr[1:0].
  - SW: wdata = d, wmask = 1111.
- `mem_rsp_valid` is ignored in IDLE, REQ and DONE. Memory never returns a response before its request handshake.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `mem_req_valid`=0, `mem_req_wen`=0, `mem_req_wmask`=0000, `mem_req_addr`=0, `mem_req_wdata`=0, `out_valid`=0, `out_data`=0, `out_err`=0.
- **Reset mid-transaction:** the transaction is abandoned and the LSU returns to IDLE next cycle. A late response is dropped because it arrives while in IDLE.
- **Memory op latency**, with the input accepted in cycle 0:
  - `mem_req_valid` asserts in cycle 1.
  - With ready in cycle 1 and the response in cycle 2, `out_valid` asserts in cycle 3. This is the minimum.
  - Each stall cycle on ready or response adds one cycle.
- **Pass-through and error ops:** `out_valid` asserts in cycle 1.
- **Back-to-back:** `in_ready` returns to 1 in the cycle after the output handshake, so the minimum spacing between accepted ops is 2 cycles (pass-through).
- All outputs are registered or decoded from state only. No combinational path from any input to any output.

## Test plan
- LW at 0x80000004, rsp 0xDEADBEEF, req_ready and rsp 1 cycle after each other -> req addr 0x80000004, wmask 0000; `out_data`=0xDEADBEEF, `out_valid` in cycle 3, `out_err`=0.
- LB at 0x80000003 and LBU at 0x80000003, rsp 0x80FF7F00 -> LB `out_data`=0xFFFFFF80, LBU 0x00000080. LH at 0x80000002 -> 0xFFFF80FF.
- SB at 0x80000001, d=0x123456AB -> wdata 0xABABABAB, wmask 0010, wen 1. SH at 0x80000002, d=0x0000BEEF -> wdata 0xBEEFBEEF, wmask 1100. Each completes with `out_data`=0 after rsp.
- LW at 0x80000002 and SH at 0x80000001 -> no `mem_req_valid` ever; `out_valid` in cycle 1 with `out_err`=1, `out_data`=0.
- Stalls: `mem_req_ready` held low 5 cycles, rsp 3 cycles later, `out_ready` low 2 cycles -> req fields constant while stalled, `in_ready`=0 throughout, single `out_valid` handshake, then `in_ready`=1.
- `rst` asserted in WAIT, then a stale `mem_rsp_valid` arrives -> IDLE with all outputs at reset values; the stale rsp produces no `out_valid`. Pass-through op 0x12345678 next -> `out_data` 0x12345678 in cycle 1.

Source files
------------

// File: rtl/ysyx22041405_lsu.sv
// Load/store unit: one memory transaction at a time over a valid/ready bus,
// with load alignment/extension and store lane replication.
module ysyx22041405_lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic [2:0]       in_funct3,
    input  logic             in_load,
    input  logic             in_store,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    output logic             mem_req_wen,
    output logic [WIDTH-1:0] mem_req_wdata,
    output logic [3:0]       mem_req_wmask,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             ld_q, ld_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;

    logic             is_mem;
    logic             bad_op;
    logic             misalign;
    logic [WIDTH-1:0] st_data;
    logic [3:0]       st_mask;
    logic [WIDTH-1:0] rsp_sh;
    logic [WIDTH-1:0] ld_data;

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign out_valid     = (state_q == S_DONE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign out_data      = out_data_q;
    assign out_err       = out_err_q;

    // Decode of the incoming op, used only on acceptance in IDLE.
    always_comb begin
        is_mem   = in_load | in_store;
        misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0])
                 | ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        bad_op   = (in_load && !(in_funct3 inside {3'b000, 3'b001, 3'b010,
                                                  3'b100, 3'b101}))
                 | (in_store && !(in_funct3 inside {3'b000, 3'b001, 3'b010}))
                 | (is_mem && misalign);
        st_data  = in_wdata;
        st_mask  = 4'b1111;
        unique case (in_funct3[1:0])
            2'b00: begin
                st_data = {4{in_wdata[7:0]}};
                st_mask = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                st_data = {2{in_wdata[15:0]}};
                st_mask = 4'b0011 << in_addr[1:0];
            end
            default: begin
                st_data = in_wdata;
                st_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rsp_sh  = mem_rsp_data >> {off_q, 3'b000};
        ld_data = rsp_sh;
        unique case (f3_q)
            3'b000:  ld_data = {{(WIDTH-8){rsp_sh[7]}}, rsp_sh[7:0]};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, rsp_sh[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){rsp_sh[15]}}, rsp_sh[15:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, rsp_sh[15:0]};
            default: ld_data = rsp_sh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        ld_d       = ld_q;
        f3_d       = f3_q;
        off_d      = off_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_err_d = 1'b0;
                    if (!is_mem) begin
                        out_data_d = in_addr;
                        state_d    = S_DONE;
                    end else if (bad_op) begin
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        addr_d  = {in_addr[WIDTH-1:2], 2'b00};
                        wen_d   = in_store;
                        wdata_d = st_data;
                        wmask_d = in_store ? st_mask : 4'b0000;
                        ld_d    = in_load;
                        f3_d    = in_funct3;
                        off_d   = in_addr[1:0];
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    out_data_d = ld_q ? ld_data : '0;
                    state_d    = S_DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= 4'b0000;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            ld_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            ld_q       <= ld_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
        end
    end

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Scoreboard bench for ysyx22041405_lsu: directed cases, stalls, reset and
// randomized ops against an arithmetic reference model.
module tb_ysyx22041405_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_load;
    logic        in_store;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    ysyx22041405_lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_load(in_load), .in_store(in_store),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } out_t;

    req_t rq[$];
    out_t oq[$];

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    bit mem_auto = 1'b1;
    int req_stall = -1;
    int rsp_stall = -1;
    int ordy_mode = 1;
    int ordy_hold = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: what the bus should see and what WBU should get.
    function automatic void model(input logic ld, input logic st,
                                  input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rsp,
                                  output req_t r, output out_t o,
                                  output logic mem);
        int          sz;
        int          off;
        logic        legal;
        logic [31:0] w;
        longint      uv;
        longint      bits;
        mem = 1'b0;
        r = '0;
        o = '0;
        if (!ld && !st) begin
            o.data = a;
            return;
        end
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        sz = 1 << f3[1:0];
        if (!legal || (a % sz) != 0) begin
            o.err = 1'b1;
            return;
        end
        off = int'(a % 4);
        mem = 1'b1;
        r.addr = a - (a % 4);
        r.wen = st;
        r.rdata = rsp;
        if (st) begin
            if (sz == 1) begin
                r.wmask = 4'(1 << off);
                r.wdata = (d & 32'hFF) * 32'h01010101;
            end else if (sz == 2) begin
                r.wmask = 4'(3 << off);
                r.wdata = (d & 32'hFFFF) * 32'h00010001;
            end else begin
                r.wmask = 4'hF;
                r.wdata = d;
            end
        end else begin
            w = rsp >> (8 * off);
            bits = 8 * sz;
            uv = longint'(w) & ((64'd1 << bits) - 1);
            if (!f3[2] && bits < 32 && uv >= (64'd1 << (bits - 1)))
                uv = uv - (64'd1 << bits);
            o.data = uv[31:0];
        end
    endfunction

    // Drive one op from a negedge; returns at the first negedge after accept.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rsp, input bit sb);
        req_t r;
        out_t o;
        logic mem;
        int   n;
        model(ld, st, f3, a, d, rsp, r, o, mem);
        if (sb) begin
            if (mem) rq.push_back(r);
            oq.push_back(o);
        end
        in_valid = 1'b1;
        in_load = ld;
        in_store = st;
        in_funct3 = f3;
        in_addr = a;
        in_wdata = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_addr = $urandom;
        in_wdata = $urandom;
        in_funct3 = 3'($urandom);
        in_load = 1'b0;
        in_store = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rsp,
                           input int exp_lat);
        int lat;
        int n;
        issue(ld, st, f3, a, d, rsp, 1'b1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Memory responder: checks each request against the expected bus fields.
    initial begin
        req_t r;
        int   s;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (mem_auto && !rst && mem_req_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=%h expected=none",
                             mem_req_addr);
                    r = '0;
                end else begin
                    r = rq.pop_front();
                end
                s = (req_stall >= 0) ? req_stall : int'($urandom % 3);
                for (int i = 0; i <= s; i++) begin
                    chk("req_valid", 32'(mem_req_valid), 32'd1);
                    chk("req_addr", mem_req_addr, r.addr);
                    chk("req_wen", 32'(mem_req_wen), 32'(r.wen));
                    chk("req_wmask", 32'(mem_req_wmask), 32'(r.wmask));
                    if (r.wen) chk("req_wdata", mem_req_wdata, r.wdata);
                    mem_req_ready = (i == s);
                    @(negedge clk);
                end
                mem_req_ready = 1'b0;
                s = (rsp_stall >= 0) ? rsp_stall : int'($urandom % 3);
                repeat (s) @(negedge clk);
                mem_rsp_valid = 1'b1;
                mem_rsp_data = r.rdata;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                mem_rsp_data = $urandom;
            end
        end
    end

    // Output monitor: pops the scoreboard on every out handshake.
    initial begin
        out_t o;
        int   hold;
        logic rdy;
        out_ready = 1'b0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (out_valid && !rst) begin
                if (ordy_mode == 0) rdy = 1'($urandom % 2);
                else if (ordy_mode == 1) rdy = 1'b1;
                else rdy = (hold >= ordy_hold);
                hold++;
                out_ready = rdy;
                if (rdy) begin
                    hs_cnt++;
                    hold = 0;
                    if (oq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%h expected=none",
                                 out_data);
                    end else begin
                        o = oq.pop_front();
                        chk("out_data", out_data, o.data);
                        chk("out_err", 32'(out_err), 32'(o.err));
                    end
                end
            end else begin
                out_ready = 1'b0;
                hold = 0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_req_wen"}, 32'(mem_req_wen), 32'd0);
        chk({tag, "_req_wmask"}, 32'(mem_req_wmask), 32'd0);
        chk({tag, "_req_addr"}, mem_req_addr, 32'd0);
        chk({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_err"}, 32'(out_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          hs0;
        int          n;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_wdata = '0;
        in_funct3 = '0;
        in_load = 1'b0;
        in_store = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        req_stall = 0;
        rsp_stall = 0;
        ordy_mode = 1;
        run_dir("lw", 1, 0, 3'b010, 32'h80000004, 0, 32'hDEADBEEF, 3);
        run_dir("lb", 1, 0, 3'b000, 32'h80000003, 0, 32'h80FF7F00, 3);
        run_dir("lbu", 1, 0, 3'b100, 32'h80000003, 0, 32'h80FF7F00, 3);
        run_dir("lh", 1, 0, 3'b001, 32'h80000002, 0, 32'h80FF7F00, 3);
        run_dir("sb", 0, 1, 3'b000, 32'h80000001, 32'h123456AB, 0, 3);
        run_dir("sh", 0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 0, 3);
        run_dir("lw_mis", 1, 0, 3'b010, 32'h80000002, 0, 0, 1);
        run_dir("sh_mis", 0, 1, 3'b001, 32'h80000001, 32'h1234, 0, 1);
        run_dir("ld_ill", 1, 0, 3'b011, 32'h80000000, 0, 0, 1);
        run_dir("st_ill", 0, 1, 3'b100, 32'h80000000, 5, 0, 1);
        run_dir("pass", 0, 0, 3'b010, 32'hCAFEF00D, 0, 0, 1);

        // Stalled transaction: ready low 5, rsp 3 later, out_ready low 2.
        req_stall = 5;
        rsp_stall = 3;
        ordy_mode = 2;
        ordy_hold = 2;
        hs0 = hs_cnt;
        issue(1, 0, 3'b010, 32'h80000010, 0, 32'h0BADF00D, 1'b1);
        k = 1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("stall_idle_cycle", 32'(k), 32'd14);
        chk("stall_handshakes", 32'(hs_cnt - hs0), 32'd1);

        // Reset while waiting for the response, then a stale response.
        req_stall = 0;
        rsp_stall = 0;
        ordy_mode = 1;
        mem_auto = 1'b0;
        issue(1, 0, 3'b010, 32'h80000008, 0, 0, 1'b0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h55AA55AA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            chk("stale_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        mem_auto = 1'b1;
        run_dir("pass_after_rst", 0, 0, 3'b000, 32'h12345678, 0, 0, 1);

        // Randomized traffic with random stalls and back-pressure.
        req_stall = -1;
        rsp_stall = -1;
        ordy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom % 4);
            ld = (k == 1 || k == 2);
            st = (k == 3);
            if ($urandom % 4 == 0) f3 = 3'($urandom);
            else if (ld) f3 = lf3[$urandom % 5];
            else f3 = 3'($urandom % 3);
            a = $urandom;
            if ($urandom % 3 != 0) a = a & ~(32'((1 << f3[1:0]) - 1));
            issue(ld, st, f3, a, $urandom, $urandom, 1'b1);
            repeat ($urandom % 3) @(negedge clk);
        end
        n = 0;
        while ((oq.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out_queue", 32'(oq.size()), 32'd0);
        chk("drain_req_queue", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
